// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access-size encodings,
// FSM states and per-size byte-count / lane-mask helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MERGE,
        CAP,
        WR,
        RESP
    } lsu_state_e;

    // Bytes touched by each access size, indexed by the size encoding.
    localparam logic [3:0] SIZE_BYTES [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

    // Low byte-offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(lsu_size_e size);
        return 3'(SIZE_BYTES[size] - 4'd1);
    endfunction

    function automatic logic [63:0] lane_mask(lsu_size_e size);
        case (size)
            SIZE_B:  return 64'h0000_0000_0000_00FF;
            SIZE_H:  return 64'h0000_0000_0000_FFFF;
            SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle between the memory stage (master) and the
// load/store unit (slave).
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        misalign;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, misalign
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, misalign
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data from a RAM word,
// and merges sub-doubleword store data into a RAM word for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  offset_i,
    input  lsu_size_e   size_i,
    input  logic        signed_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_data_o,
    output logic [63:0] merged_o
);

    logic [5:0]  shamt;
    logic [63:0] lanes;
    logic [63:0] mask;
    logic        sign;

    assign shamt = {offset_i, 3'b000};
    assign lanes = word_i >> shamt;
    assign mask  = lane_mask(size_i);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        load_data_o = lanes;
        sign        = 1'b0;
        case (size_i)
            SIZE_B: begin
                sign        = signed_i & lanes[7];
                load_data_o = {{56{sign}}, lanes[7:0]};
            end
            SIZE_H: begin
                sign        = signed_i & lanes[15];
                load_data_o = {{48{sign}}, lanes[15:0]};
            end
            SIZE_W: begin
                sign        = signed_i & lanes[31];
                load_data_o = {{32{sign}}, lanes[31:0]};
            end
            default: load_data_o = lanes;
        endcase
    end

    // Offsets reaching here are always size-aligned, so the shifted lanes never straddle the word.
    assign merged_o = (word_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer to a 64-bit word RAM with read-modify-write sub-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN: fault misaligned requests instead of forcing alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clock,
    input  logic              reset_n,
    lsu_if.slave              bus,
    output logic [63:0]       ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    input  logic [63:0]       ram_out
);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    lsu_size_e         size_q, size_d;
    logic              signed_q, signed_d;
    logic [2:0]        offset_q, offset_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [63:0]       ram_in_q, ram_in_d;
    logic              ram_write_q, ram_write_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;

    lsu_size_e   req_size;
    logic [2:0]  req_offset;
    logic        req_fault;
    logic [63:0] load_data;
    logic [63:0] merged;
    logic        unused_addr_hi;

    assign req_size       = lsu_size_e'(bus.req_size);
    assign req_offset     = bus.req_addr[2:0] & ~align_mask(req_size);
    assign unused_addr_hi = ^bus.req_addr[63:ADDR_W+3];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign req_fault    = (bus.req_addr[2:0] & align_mask(req_size)) != 3'b000;
    assign bus.misalign = misalign_q;
`else
    assign req_fault    = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .word_i      (ram_out),
        .offset_i    (offset_q),
        .size_i      (size_q),
        .signed_i    (signed_q),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        size_d        = size_q;
        signed_d      = signed_q;
        offset_d      = offset_q;
        wdata_d       = wdata_q;
        ram_address_d = ram_address_q;
        ram_in_d      = ram_in_q;
        resp_rdata_d  = resp_rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d       = bus.req_write;
                    size_d        = req_size;
                    signed_d      = bus.req_signed;
                    offset_d      = req_offset;
                    wdata_d       = bus.req_wdata;
                    ram_address_d = bus.req_addr[ADDR_W+2:3];
                    resp_rdata_d  = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_d    = req_fault;
`endif
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (bus.req_write && req_size == SIZE_D) begin
                        // Whole-word stores skip the read: the store data is the RAM word.
                        ram_in_d = bus.req_wdata;
                        state_d  = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = write_q ? MERGE : CAP;
            CAP: begin
                resp_rdata_d = load_data;
                state_d      = RESP;
            end
            MERGE: begin
                ram_in_d = merged;
                state_d  = WR;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are registered copies of the next state, so they align with it cycle-for-cycle.
        ram_write_d  = (state_d == WR);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            size_q        <= SIZE_B;
            signed_q      <= 1'b0;
            offset_q      <= 3'b000;
            wdata_q       <= '0;
            ram_address_q <= '0;
            ram_in_q      <= '0;
            ram_write_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            write_q       <= write_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            offset_q      <= offset_d;
            wdata_q       <= wdata_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            ram_write_q   <= ram_write_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) misalign_q <= 1'b0;
        else          misalign_q <= misalign_d;
    end
`endif

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign ram_in         = ram_in_q;
    assign ram_address    = ram_address_q;
    assign ram_write      = ram_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic compared against a byte-addressed reference memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W = 13;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic [63:0]       ram_in;
    logic [63:0]       ram_out;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_write;

    logic [63:0] mem     [WORDS];
    logic [7:0]  ref_mem [WORDS*8];
    int n_checks = 0;
    int n_fail   = 0;

    lsu_if bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .ram_in      (ram_in),
        .ram_address (ram_address),
        .ram_write   (ram_write),
        .ram_out     (ram_out)
    );

    always #5 clock = ~clock;

    // Registered-read RAM: data appears the cycle after a non-write address.
    always @(posedge clock) begin
        if (ram_write) mem[ram_address] <= ram_in;
        else           ram_out <= mem[ram_address];
    end

    // Reference model: byte array, natural alignment rules, plain arithmetic.
    function automatic void model_op(input logic wr, input logic [1:0] sz, input logic sg,
                                     input logic [63:0] addr, input logic [63:0] wd,
                                     output logic [63:0] rdata, output logic mis,
                                     output int lat, output int writes);
        int n    = 1 << sz;
        int base = int'(addr[ADDR_W+2:0]);
        rdata  = '0;
        mis    = 1'b0;
        writes = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((base % n) != 0) begin
            mis = 1'b1;
            lat = 1;
            return;
        end
`endif
        base = base - (base % n);
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[base+i] = wd[8*i +: 8];
            lat    = (n == 8) ? 2 : 4;
            writes = 1;
        end else begin
            for (int i = 0; i < n; i++) rdata[8*i +: 8] = ref_mem[base+i];
            if (sg && n < 8 && rdata[8*n-1])
                for (int i = n; i < 8; i++) rdata[8*i +: 8] = 8'hFF;
            lat = 3;
        end
    endfunction

    task automatic scramble_req();
        bus.req_write  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = {$urandom, $urandom};
        bus.req_wdata  = {$urandom, $urandom};
    endtask

    // Issues one request, returns what the DUT did, cycle numbers counted from the accept edge.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output logic [63:0] rdata, output logic mis, output int lat,
                          output int writes, output int wr_cyc, output logic [ADDR_W-1:0] wr_addr);
        int waited = 0;
        rdata = 'x; mis = 1'bx; lat = -1; writes = 0; wr_cyc = -1; wr_addr = 'x;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        scramble_req();
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clock);
            if (ram_write === 1'b1) begin
                writes++;
                wr_cyc  = k;
                wr_addr = ram_address;
            end
            if (bus.resp_valid === 1'b1) begin
                lat   = k;
                rdata = bus.resp_rdata;
                mis   = bus.misalign;
            end
        end
        if (lat > 0) begin
            @(negedge clock);
            n_checks++;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL after_resp: resp_valid=%b req_ready=%b, required 0 and 1",
                         bus.resp_valid, bus.req_ready);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.misalign, ram_write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s_flags: ready/valid/misalign/write=%b, required 1000", tag,
                     {bus.req_ready, bus.resp_valid, bus.misalign, ram_write});
        end
        n_checks++;
        if (bus.resp_rdata !== 64'h0 || ram_in !== 64'h0 || ram_address !== '0) begin
            n_fail++;
            $display("FAIL %s_data: rdata=%h ram_in=%h ram_address=%h, required all 0", tag,
                     bus.resp_rdata, ram_in, ram_address);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        scramble_req();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_double();
        logic [63:0] rd, m_rd;
        logic mis, m_mis;
        int lat, wr, wc, m_lat, m_wr;
        logic [ADDR_W-1:0] wa;
        model_op(1'b1, SIZE_D, 1'b0, 64'h10, 64'h1122334455667788, m_rd, m_mis, m_lat, m_wr);
        do_req(1'b1, SIZE_D, 1'b0, 64'h10, 64'h1122334455667788, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (lat !== 2 || wr !== 1 || wc !== 1 || wa !== 13'd2 || rd !== 64'h0) begin
            n_fail++;
            $display("FAIL dstore: lat=%0d writes=%0d wr_cyc=%0d addr=%0d rdata=%h, required 2 1 1 2 0",
                     lat, wr, wc, wa, rd);
        end
        do_req(1'b0, SIZE_D, 1'b0, 64'h10, 64'h0, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (rd !== 64'h1122334455667788 || lat !== 3 || wr !== 0) begin
            n_fail++;
            $display("FAIL dload: rdata=%h lat=%0d writes=%0d, required 1122334455667788 3 0", rd, lat, wr);
        end
    endtask

    task automatic test_byte_store();
        logic [63:0] rd, m_rd;
        logic mis, m_mis;
        int lat, wr, wc, m_lat, m_wr;
        logic [ADDR_W-1:0] wa;
        model_op(1'b1, SIZE_B, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, m_rd, m_mis, m_lat, m_wr);
        do_req(1'b1, SIZE_B, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (lat !== 4 || wr !== 1 || wc !== 3 || wa !== 13'd2) begin
            n_fail++;
            $display("FAIL bstore: lat=%0d writes=%0d wr_cyc=%0d addr=%0d, required 4 1 3 2", lat, wr, wc, wa);
        end
        do_req(1'b0, SIZE_D, 1'b0, 64'h10, 64'h0, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (rd !== 64'h11223344AB667788) begin
            n_fail++;
            $display("FAIL bstore_readback: got %h, required 11223344ab667788", rd);
        end
    endtask

    task automatic test_signed_loads();
        logic [63:0] rd;
        logic mis;
        int lat, wr, wc;
        logic [ADDR_W-1:0] wa;
        do_req(1'b0, SIZE_B, 1'b1, 64'h13, 64'h0, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFAB) begin
            n_fail++;
            $display("FAIL lb_signed: got %h, required ffffffffffffffab", rd);
        end
        do_req(1'b0, SIZE_B, 1'b0, 64'h13, 64'h0, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (rd !== 64'hAB) begin
            n_fail++;
            $display("FAIL lb_unsigned: got %h, required ab", rd);
        end
        do_req(1'b0, SIZE_H, 1'b1, 64'h16, 64'h0, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (rd !== 64'h1122) begin
            n_fail++;
            $display("FAIL lh_signed: got %h, required 1122", rd);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] rd;
        logic mis;
        int lat, wr, wc;
        logic [ADDR_W-1:0] wa;
        do_req(1'b0, SIZE_H, 1'b0, 64'h11, 64'h0, rd, mis, lat, wr, wc, wa);
        n_checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (lat !== 1 || mis !== 1'b1 || rd !== 64'h0 || wr !== 0) begin
            n_fail++;
            $display("FAIL misalign: lat=%0d misalign=%b rdata=%h writes=%0d, required 1 1 0 0", lat, mis, rd, wr);
        end
`else
        if (lat !== 3 || mis !== 1'b0 || rd !== 64'h7788 || wr !== 0) begin
            n_fail++;
            $display("FAIL misalign: lat=%0d misalign=%b rdata=%h writes=%0d, required 3 0 7788 0", lat, mis, rd, wr);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int wr_seen = 0;
        int rv_seen = 0;
        logic [63:0] rd;
        logic mis;
        int lat, wr, wc;
        logic [ADDR_W-1:0] wa;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = SIZE_B;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'h13;
        bus.req_wdata  = 64'hCD;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        scramble_req();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int k = 0; k < 8; k++) begin
            if (k == 4) reset_n = 1'b1;
            @(negedge clock);
            if (ram_write !== 1'b0) wr_seen++;
            if (bus.resp_valid !== 1'b0) rv_seen++;
        end
        n_checks++;
        if (wr_seen !== 0 || rv_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: write cycles=%0d resp cycles=%0d, required 0 0", wr_seen, rv_seen);
        end
        do_req(1'b0, SIZE_D, 1'b0, 64'h10, 64'h0, rd, mis, lat, wr, wc, wa);
        n_checks++;
        if (rd !== 64'h11223344AB667788) begin
            n_fail++;
            $display("FAIL abort_readback: got %h, required 11223344ab667788", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp1, exp2, got[$];
        logic m_mis;
        int m_lat, m_wr, accept_cyc;
        int cyc[$];
        model_op(1'b0, SIZE_W, 1'b0, 64'h10, 64'h0, exp1, m_mis, m_lat, m_wr);
        model_op(1'b0, SIZE_B, 1'b1, 64'h13, 64'h0, exp2, m_mis, m_lat, m_wr);
        accept_cyc = -1;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_size   = SIZE_W;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'h10;
        @(posedge clock);
        #1;
        bus.req_size   = SIZE_B;
        bus.req_signed = 1'b1;
        bus.req_addr   = 64'h13;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus.resp_valid === 1'b1) begin
                cyc.push_back(k);
                got.push_back(bus.resp_rdata);
            end
            if (bus.req_ready === 1'b1 && bus.req_valid && accept_cyc < 0) begin
                accept_cyc = k;
                @(posedge clock);
                #1;
                bus.req_valid = 1'b0;
                scramble_req();
            end
        end
        n_checks++;
        if (accept_cyc !== 4) begin
            n_fail++;
            $display("FAIL b2b_accept: second accepted in cycle %0d, required 4", accept_cyc);
        end
        n_checks++;
        if (cyc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d responses, required 2", cyc.size());
        end else if (cyc[0] !== 3 || cyc[1] !== 7 || got[0] !== exp1 || got[1] !== exp2) begin
            n_fail++;
            $display("FAIL b2b_resp: cycles %0d,%0d data %h,%h, required 3,7 %h,%h",
                     cyc[0], cyc[1], got[0], got[1], exp1, exp2);
        end
    endtask

    task automatic test_random();
        logic [63:0] addr, wd, rd, m_rd;
        logic wr_i, sg, mis, m_mis;
        logic [1:0] sz;
        int lat, wr, wc, m_lat, m_wr;
        logic [ADDR_W-1:0] wa;
        for (int i = 0; i < 80; i++) begin
            wr_i = 1'($urandom);
            sz   = 2'($urandom);
            sg   = 1'($urandom);
            wd   = {$urandom, $urandom};
            addr = {$urandom, $urandom};
            addr[ADDR_W+2:3] = (i % 8 == 0) ? '1 : ADDR_W'($urandom_range(0, 15));
            model_op(wr_i, sz, sg, addr, wd, m_rd, m_mis, m_lat, m_wr);
            do_req(wr_i, sz, sg, addr, wd, rd, mis, lat, wr, wc, wa);
            n_checks++;
            if (rd !== m_rd || mis !== m_mis || lat !== m_lat || wr !== m_wr ||
                (m_wr == 1 && wa !== addr[ADDR_W+2:3])) begin
                n_fail++;
                $display("FAIL rand_%0d: wr=%b sz=%0d sg=%b addr=%h rdata=%h mis=%b lat=%0d writes=%0d waddr=%h, required %h %b %0d %0d %h",
                         i, wr_i, sz, sg, addr, rd, mis, lat, wr, wa, m_rd, m_mis, m_lat, m_wr, addr[ADDR_W+2:3]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 64'h0;
        for (int i = 0; i < WORDS * 8; i++) ref_mem[i] = 8'h0;
        test_reset();
        test_double();
        test_byte_store();
        test_signed_loads();
        test_misalign();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
